// File: rtl/exc_ctrl.sv
// Exception resolver: resolves CP0/memory-stage exceptions, drives CP0 inputs and sequences the flush.
// Optional macro EXC_CTRL_IV_EN: interrupts redirect to EXC_VECTOR+0x200 when Cause.IV is set.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h00000020,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_raw_i,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_exc_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [5:0]  int_sync_o,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        busy_o
);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic        ds_q, ds_d;
  logic        flush_q, flush_d;
  logic [31:0] pc_q, pc_d;
  logic [5:0]  sync_q [SYNC_STAGES];

  logic [31:0] status_eff, cause_eff, epc_eff;
  logic        int_pend;
  logic [31:0] exc_code, target_pc;
  logic        unused_bits;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= int_raw_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Bypass an mtc0 still in write-back; only IV/IP[1:0]/bit22 of Cause are software-writable.
  always_comb begin
    status_eff = cp0_status_i;
    cause_eff  = cp0_cause_i;
    epc_eff    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        5'd12: status_eff = wb_cp0_data_i;
        5'd13: begin
          cause_eff[9:8] = wb_cp0_data_i[9:8];
          cause_eff[22]  = wb_cp0_data_i[22];
          cause_eff[23]  = wb_cp0_data_i[23];
        end
        5'd14: epc_eff = wb_cp0_data_i;
        default: ;
      endcase
    end
  end

  assign int_pend = ((status_eff[15:8] & cause_eff[15:8]) != 8'h00) &&
                    !status_eff[1] && status_eff[0];

  always_comb begin
    if      (int_pend)     exc_code = 32'h1;
    else if (mem_exc_i[0]) exc_code = 32'h8;
    else if (mem_exc_i[1]) exc_code = 32'ha;
    else if (mem_exc_i[2]) exc_code = 32'hd;
    else if (mem_exc_i[3]) exc_code = 32'hc;
    else if (mem_exc_i[4]) exc_code = 32'he;
    else                   exc_code = 32'h0;
  end

  always_comb begin
    target_pc = EXC_VECTOR;
    if (exc_code == 32'he) target_pc = epc_eff;
`ifdef EXC_CTRL_IV_EN
    else if (exc_code == 32'h1 && cause_eff[23]) target_pc = EXC_VECTOR + 32'h200;
`else
`endif
  end

  assign unused_bits = ^{status_eff, cause_eff};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    type_d  = '0;
    addr_d  = '0;
    ds_d    = 1'b0;
    flush_d = flush_q;
    pc_d    = pc_q;
    case (state_q)
      IDLE: begin
        flush_d = 1'b0;
        pc_d    = '0;
        if (mem_valid_i && exc_code != 32'h0) begin
          state_d = FLUSH;
          type_d  = exc_code;
          addr_d  = mem_pc_i;
          ds_d    = mem_in_delayslot_i;
          flush_d = 1'b1;
          pc_d    = target_pc;
          cnt_d   = 4'(FLUSH_CYCLES - 1);
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          flush_d = 1'b0;
          pc_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      type_q  <= '0;
      addr_q  <= '0;
      ds_q    <= 1'b0;
      flush_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      ds_q    <= ds_d;
      flush_q <= flush_d;
      pc_q    <= pc_d;
    end
  end

  assign int_sync_o          = sync_q[SYNC_STAGES-1];
  assign excepttype_o        = type_q;
  assign current_inst_addr_o = addr_q;
  assign is_in_delayslot_o   = ds_q;
  assign flush_o             = flush_q;
  assign new_pc_o            = pc_q;
  assign busy_o              = (state_q == FLUSH);

endmodule
